// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60Hz timing constants and frame-buffer address helper.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  // Row-major linear address; a 640-wide frame uses shift-add instead of a multiplier.
  function automatic logic [31:0] lin_addr(input int unsigned width, input logic [10:0] col, input logic [10:0] row);
    return (width == 640) ? (32'(row) << 9) + (32'(row) << 7) + 32'(col)
                          : 32'(row) * width + 32'(col);
  endfunction
endpackage

// File: rtl/fb_ram.sv
// fb_ram: 1-bit simple dual-port frame memory, registered read, old data on collision.
module fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);
  logic mem [DEPTH];
  logic rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: pixel-write sink into a 1-bit frame buffer, scanned out as VGA.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        pixel_color,
  input  logic        pixel_write,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n,
  output logic        frame_start
);
  localparam int H_TOT = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DEPTH = H_ACT * V_ACT;
  localparam int AW    = $clog2(DEPTH);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pix_en_q, pix_en_d, vclk_q, vclk_d, col_q, col_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic          h_end, v_end, active, rdata, we;
  logic [31:0]   hc, vc;
  logic [AW-1:0] waddr, raddr;

  assign hc    = 32'(hcnt_q);
  assign vc    = 32'(vcnt_q);
  assign we    = pixel_write && 32'(x) < H_ACT && 32'(y) < V_ACT;
  assign waddr = AW'(lin_addr(H_ACT, x, y));
  assign raddr = AW'(lin_addr(H_ACT, 11'(hcnt_q), 11'(vcnt_q)));

  fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk50), .we_i(we), .waddr_i(waddr), .wdata_i(pixel_color),
    .raddr_i(raddr), .rdata_o(rdata)
  );

  // Outputs are captured on pix_en from the same counters that addressed the RAM,
  // so colour, sync and blank all lag the counters by one pixel period.
  always_comb begin
    h_end    = hcnt_q == HW'(H_TOT - 1);
    v_end    = vcnt_q == VW'(V_TOT - 1);
    active   = hc < H_ACT && vc < V_ACT;
    pix_en_d = !pix_en_q;
    vclk_d   = pix_en_q;
    hcnt_d   = !pix_en_q ? hcnt_q : h_end ? '0 : hcnt_q + 1'b1;
    vcnt_d   = !(pix_en_q && h_end) ? vcnt_q : v_end ? '0 : vcnt_q + 1'b1;
    col_d    = pix_en_q ? active & rdata : col_q;
    blank_d  = pix_en_q ? active : blank_q;
    hs_d     = pix_en_q ? !(hc >= H_ACT + H_FRONT && hc < H_ACT + H_FRONT + H_PULSE) : hs_q;
    vs_d     = pix_en_q ? !(vc >= V_ACT + V_FRONT && vc < V_ACT + V_FRONT + V_PULSE) : vs_q;
    fs_d     = pix_en_q && h_end && vcnt_q == VW'(V_ACT - 1);
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      pix_en_q <= 1'b1;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      vclk_q   <= 1'b0;
      col_q    <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      vclk_q   <= vclk_d;
      col_q    <= col_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      fs_q     <= fs_d;
    end
  end

  assign VGA_R       = {8{col_q}};
  assign VGA_G       = {8{col_q}};
  assign VGA_B       = {8{col_q}};
  assign VGA_CLK     = vclk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = blank_q;
  assign VGA_SYNC_n  = 1'b0;
  assign frame_start = fs_q;
endmodule
